// File: rtl/pwm_capture.sv
// Measures period and high time of an external PWM waveform, packed as {period-1, high-1}.
// Latency: SYNC_STAGES+1 cycles from a pwm_in rising edge to cap_valid; no backpressure, each result overwrites the last.
module pwm_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pwm_in,
    output logic [2*CNT_W-1:0] cap_reg,
    output logic               cap_valid,
    output logic               no_signal,
    output logic               in_level
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W:0] CNT_MAX = {1'b1, {CNT_W{1'b0}}};

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   fall;
    logic [CNT_W:0]         per_cnt;
    logic [CNT_W:0]         hi_cnt;
    logic [CNT_W-1:0]       per_field;
    logic [CNT_W-1:0]       hi_field;

    assign s        = sync_q[SYNC_STAGES-1];
    assign in_level = s;
    assign rise     = s & ~s_d;
    assign fall     = ~s & s_d;

    // Truncating before subtracting wraps a full 2^CNT_W period to all-ones.
    assign per_field = per_cnt[CNT_W-1:0] - 1'b1;
    assign hi_field  = hi_cnt[CNT_W-1:0] - 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            s_d       <= 1'b0;
            state     <= IDLE;
            per_cnt   <= '0;
            hi_cnt    <= '0;
            cap_reg   <= '0;
            cap_valid <= 1'b0;
            no_signal <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_d       <= s;
            cap_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state   <= HIGH;
                        per_cnt <= CNT_ONE;
                        hi_cnt  <= CNT_ONE;
                    end
                end
                HIGH: begin
                    if (per_cnt == CNT_MAX) begin
                        state     <= IDLE;
                        no_signal <= 1'b1;
                        per_cnt   <= '0;
                        hi_cnt    <= '0;
                    end else if (fall) begin
                        state   <= LOW;
                        per_cnt <= per_cnt + 1'b1;
                    end else begin
                        per_cnt <= per_cnt + 1'b1;
                        hi_cnt  <= hi_cnt + 1'b1;
                    end
                end
                LOW: begin
                    // A rise wins over the timeout so a period of exactly 2^CNT_W is legal.
                    if (rise) begin
                        state     <= HIGH;
                        cap_reg   <= {per_field, hi_field};
                        cap_valid <= 1'b1;
                        no_signal <= 1'b0;
                        per_cnt   <= CNT_ONE;
                        hi_cnt    <= CNT_ONE;
                    end else if (per_cnt == CNT_MAX) begin
                        state     <= IDLE;
                        no_signal <= 1'b1;
                        per_cnt   <= '0;
                        hi_cnt    <= '0;
                    end else begin
                        per_cnt <= per_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    per_cnt <= '0;
                    hi_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the PWM generator: samples an external PWM waveform and measures its period and high time in clock cycles.
- Reports the result in the same 16-bit packing the generator consumes: [15:8] = period count_to, [7:0] = duty compare value.
- Used for loopback self-test of the synth audio PWM path and for reading external PWM control inputs. Waveforms with no edges are flagged as no-signal.

Parameters:
- SYNC_STAGES, 2, number of input synchronizer flops (minimum 2).
- CNT_W, 8, width of each reported field; the counters are CNT_W+1 bits wide.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- pwm_in  input  1  asynchronous PWM waveform to measure.
- cap_reg  output  16  {period-1, high-1}; same encoding as the generator's pwm_reg.
- cap_valid  output  1  one-cycle pulse when cap_reg has just been updated.
- no_signal  output  1  high while no complete period has been measured since reset or since the last timeout.
- in_level  output  1  synchronized pwm_in level (last synchronizer stage).

Behaviour:
- Reset (reset=0, asynchronous): all outputs and internal registers go to their reset values:
  - cap_reg=16'h0000, cap_valid=0, no_signal=1, in_level=0.
  - All synchronizer flops=0, state=IDLE, counters=0.
- Synchronizer and edge detect:
  - pwm_in passes through SYNC_STAGES flops; the final stage is s.
  - s_d is s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d (both combinational).
- State machine: IDLE, HIGH, LOW.
  - IDLE -> HIGH on rise: per_cnt=1, hi_cnt=1. No output update.
  - HIGH: per_cnt++ and hi_cnt++ each cycle. On fall -> LOW with per_cnt++ and hi_cnt frozen.
  - LOW: per_cnt++ each cycle. On rise, publish and -> HIGH with per_cnt=1, hi_cnt=1.
- Publish (registered, visible the cycle after rise):
  - cap_reg = {per_cnt-1, hi_cnt-1}, truncated to CNT_W bits each.
  - cap_valid=1 for exactly one cycle.
  - no_signal=0.
- Counting convention: per_cnt equals the number of clk cycles from one synchronized rise to the next. Generator settings count_to=P, duty=D<P therefore read back exactly as {P, D}.
- Timeout:
  - Trigger: in HIGH or LOW, per_cnt would exceed 2^CNT_W (256), i.e. there has been no rise within 256 cycles.
  - Action: go to IDLE, set no_signal=1, cap_valid=0, and hold cap_reg at its last value.
  - Covers a constant-high input (generator duty>=count_to) and a constant-low input. The stuck level is reported on in_level.
- Simultaneous events: rise and fall cannot coincide after synchronization. A rise on the same cycle the timeout would trigger is treated as a rise, so a period of exactly 256 is legal and reports count_to=0xFF.
- Minimum measurable period is 2 cycles. High time of 1 cycle reports duty 0.
- Reset asserted mid-measurement aborts it immediately. After release, the first rise only arms the block; the first cap_valid arrives one full period later.
- cap_valid never asserts in IDLE or on the arming rise.
- Input latency: pwm_in to in_level is SYNC_STAGES cycles. Widths are relative, so latency does not bias the measurement.

Test Plan:
- Loopback from the generator with pwm_reg=16'h0903 (period 10, high 4). Required: first cap_valid one period after the arming rise, cap_reg=16'h0903; cap_valid then repeats every 10 cycles; no_signal falls with the first valid.
- Generator with pwm_reg=16'hFF00. Required: cap_reg=16'hFF00 with cap_valid every 256 cycles, and no timeout.
- Hold pwm_in=1 for 300 cycles after a valid capture. Required: no_signal=1 exactly 256 cycles after the last rise, cap_reg unchanged, in_level=1, no cap_valid.
- Switch the generator from 16'h0903 to 16'h1F10 mid-stream. Required: after at most one transitional capture, cap_reg=16'h1F10 stably.
- Assert reset=0 while in HIGH. Required: outputs return to their reset values asynchronously (before the next clk edge). After release, the first valid appears one full period after the first rise.
- Drive pwm_in alternating 1,0 each cycle. Required: cap_reg=16'h0100, cap_valid every 2 cycles.
